// File: rtl/shl_seq_unit.sv
// Multi-cycle left-shift sequencer: one single-bit shift per clock, valid/ready in and out.
// Optional rotate mode is enabled by defining SHL_ROTATE_EN.
module shl_seq_unit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_amt,
  input  logic             in_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_d, out_valid_d;
  logic             fill_c;
  logic             drop_ovf_c;

`ifdef SHL_ROTATE_EN
  logic rot_q, rot_d;
  assign fill_c     = rot_q & data_q[WIDTH-1];
  assign drop_ovf_c = rot_q;
`else
  logic unused_rot;
  assign unused_rot = in_rot;
  assign fill_c     = 1'b0;
  assign drop_ovf_c = 1'b0;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef SHL_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = in_amt;
          ovf_d   = 1'b0;
`ifdef SHL_ROTATE_EN
          rot_d   = in_rot;
`endif
          state_d = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          data_d = {data_q[WIDTH-2:0], fill_c};
          ovf_d  = drop_ovf_c ? 1'b0 : (ovf_q | data_q[WIDTH-1]);
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef SHL_ROTATE_EN
      rot_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
`ifdef SHL_ROTATE_EN
      rot_q     <= rot_d;
`endif
    end
  end

  assign out_data = data_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_shl_seq_unit.sv
// Self-checking bench for shl_seq_unit: directed scenarios plus random jobs vs. an arithmetic model.
module tb_shl_seq_unit;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_rot, out_valid, out_ready, out_ovf;
  logic [WIDTH-1:0] in_data, out_data;
  logic [CNT_W-1:0] in_amt;

  int n_pass  = 0;
  int n_total = 0;

  shl_seq_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_rot(in_rot),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Result of a whole job from shift/rotate arithmetic
  task automatic model(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] a, input logic r,
                       output logic [WIDTH-1:0] q, output logic o);
    logic [31:0]        full;
    logic [2*WIDTH-1:0] dd;
    full = 32'(d) << a;
    q    = full[WIDTH-1:0];
    o    = |(full >> WIDTH);
`ifdef SHL_ROTATE_EN
    if (r) begin
      dd = {d, d} << (32'(a) % WIDTH);
      q  = dd[2*WIDTH-1:WIDTH];
      o  = 1'b0;
    end
`else
    if (r) o = o;
`endif
  endtask

  task automatic run_job(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] a, input logic r,
                         input int stall, input string tag);
    logic [WIDTH-1:0] eq;
    logic             eo;
    model(d, a, r, eq, eo);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_rot    = r;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_amt   = CNT_W'($urandom);
    for (int i = 0; i < int'(a); i++) begin
      chk({tag, "_busy_v"}, 32'(out_valid), 32'd0);
      chk({tag, "_busy_r"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_d"}, 32'(out_data), 32'(eq));
    chk({tag, "_o"}, 32'(out_ovf), 32'(eo));
    // Backpressure with a competing request that must not load
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data  = ~d;
      in_amt   = CNT_W'($urandom);
      in_rot   = 1'($urandom);
      @(negedge clk);
      chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_d"}, 32'(out_data), 32'(eq));
      chk({tag, "_hold_o"}, 32'(out_ovf), 32'(eo));
      chk({tag, "_hold_r"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_post_v"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_r"}, 32'(in_ready), 32'd1);
    chk({tag, "_post_d"}, 32'(out_data), 32'(eq));
    chk({tag, "_post_o"}, 32'(out_ovf), 32'(eo));
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_rot = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_r", 32'(in_ready), 32'd1);
    chk("rst_v", 32'(out_valid), 32'd0);
    chk("rst_d", 32'(out_data), 32'd0);
    chk("rst_o", 32'(out_ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a long job
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1111; in_amt = 3'd5; in_rot = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(out_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_v", 32'(out_valid), 32'd0);
    chk("mid_rst_r", 32'(in_ready), 32'd1);
    chk("mid_rst_d", 32'(out_data), 32'd0);
    chk("mid_rst_o", 32'(out_ovf), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_v2", 32'(out_valid), 32'd0);
    rst = 1'b0;
    run_job(4'b1111, 3'd5, 1'b0, 0, "after_rst");

    run_job(4'b0011, 3'd1, 1'b0, 0, "amt1");
    run_job(4'b1011, 3'd2, 1'b0, 0, "amt2");
    run_job(4'b1001, 3'd0, 1'b0, 0, "amt0");
    run_job(4'b0101, 3'd7, 1'b0, 0, "amt7");
    run_job(4'b1000, 3'd4, 1'b0, 0, "amt_eq_w");
    run_job(4'b0110, 3'd3, 1'b0, 5, "bp5");
    run_job(4'b1011, 3'd1, 1'b1, 0, "rot");
    run_job(4'b1101, 3'd6, 1'b1, 2, "rot_long");

    for (int j = 0; j < 40; j++)
      run_job(WIDTH'($urandom), CNT_W'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), $sformatf("rnd%0d", j));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
